shift_norm: RTL

Sequential normalizer for the ASIP datapath: the inverse companion of the combinational shifter. Instead of shifting an operand by a given count, it takes a value and finds the count. It shifts the operand one bit per clock until the leading one (left mode) or trailing one (right mode) reaches the boundary bit. It then returns the normalized value and the number of positions shifted. The ALU control and the future FP pack/unpack path use it through a start/busy/done handshake.

---
 rtl/shift_pkg.sv | 10 +
 rtl/shift_norm.sv | 101 ++++++++++
 2 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the normalizer and the combinational shifter:
// FSM state encoding and shift-direction constants.
package shift_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} norm_state_t;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_norm.sv
// Sequential normalizer: shifts an operand one bit per clock until its leading
// (left mode) or trailing (right mode) one reaches the boundary bit.
module shift_norm
   import shift_pkg::*;
#(
   parameter  int bus   = 32,
   localparam int cnt_w = $clog2(bus)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [bus-1:0]   a,
   input  logic             dir,
   output logic             busy,
   output logic             done,
   output logic [bus-1:0]   y,
   output logic [cnt_w-1:0] count,
   output logic             zero
);

   norm_state_t      state_q, state_d;
   logic [bus-1:0]   work_q, work_d;
   logic             dir_q, dir_d;
   logic [cnt_w-1:0] count_q, count_d;
   logic             zero_q, zero_d;

   logic             target_hit;
   logic             work_zero;
   logic [bus-1:0]   work_step;

   assign work_zero  = (work_q == '0);
   assign target_hit = (dir_q == DIR_RIGHT) ? work_q[0] : work_q[bus-1];
   assign work_step  = (dir_q == DIR_RIGHT) ? {1'b0, work_q[bus-1:1]}
                                            : {work_q[bus-2:0], 1'b0};

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      dir_d   = dir_q;
      count_d = count_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               work_d  = a;
               dir_d   = dir;
               count_d = '0;
               zero_d  = 1'b0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (work_zero) begin
               zero_d  = 1'b1;
               state_d = DONE;
            end else if (target_hit) begin
               state_d = DONE;
            end else begin
               work_d  = work_step;
               count_d = count_q + cnt_w'(1);
            end
         end
         DONE: begin
            // Accepting here gives back-to-back operation with no idle cycle.
            if (start) begin
               work_d  = a;
               dir_d   = dir;
               count_d = '0;
               zero_d  = 1'b0;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         work_q  <= '0;
         dir_q   <= DIR_LEFT;
         count_q <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         dir_q   <= dir_d;
         count_q <= count_d;
         zero_q  <= zero_d;
      end
   end

   assign busy  = (state_q == SHIFT);
   assign done  = (state_q == DONE);
   assign y     = work_q;
   assign count = count_q;
   assign zero  = zero_q;

endmodule
